debounce_array: RTL and testbench

//   N-channel parametrised button/switch conditioner: per channel a 2-FF synchroniser,
//   a stability counter and one-cycle rise/fall strobes. Replaces single-button

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_array_if.sv | 13 +
 rtl/debounce_channel.sv | 61 ++++++
 rtl/debounce_array.sv | 28 ++
 tb/tb_debounce_array.sv | 122 ++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared constants and counter-width helper for the debounce array
package debounce_pkg;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_STABLE_CYCLES = 5;
  localparam int unsigned DEF_LONG_CYCLES = 1000;
  localparam logic DEF_RESET_VAL = 1'b0;
  function automatic int unsigned ctr_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_array_if.sv
// debounce_array_if: raw pin inputs and conditioned outputs of the debounce array
interface debounce_array_if import debounce_pkg::*; #(
  parameter int unsigned CHANNELS = DEF_CHANNELS
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] long_press;
  logic any_change;
  modport master(output raw_in, input db_level, rise, fall, any_change, long_press);
  modport slave(input raw_in, output db_level, rise, fall, any_change, long_press);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: sync + stability filter + strobes; hold detector under DEBOUNCE_LONG_PRESS_EN
module debounce_channel import debounce_pkg::*; #(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VAL = DEF_RESET_VAL,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);
  localparam int unsigned CW = ctr_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("debounce_channel: STABLE_CYCLES and LONG_CYCLES must be >= 1");
  end
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      level <= RESET_VAL;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s;
        cnt <= '0;
        rise <= s;
        fall <= ~s;
      end else cnt <= cnt + CW'(1);
    end
  end
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HW = ctr_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  logic [HW-1:0] hold;
  // saturating at HOLD_MAX gives exactly one strobe per press
  always_ff @(posedge clk) begin
    if (reset || !level) begin
      hold <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= hold == HOLD_MAX - HW'(1);
      if (hold != HOLD_MAX) hold <= hold + HW'(1);
    end
  end
`else
  assign long_press = 1'b0;
`endif
endmodule

// File: rtl/debounce_array.sv
// debounce_array: N independent debounced inputs; long-press strobes when DEBOUNCE_LONG_PRESS_EN is defined
module debounce_array import debounce_pkg::*; #(
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic RESET_VAL = DEF_RESET_VAL,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input logic clk,
  input logic reset,
  debounce_array_if.slave bus
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL(RESET_VAL),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(bus.raw_in[c]),
      .level(bus.db_level[c]),
      .rise(bus.rise[c]),
      .fall(bus.fall[c]),
      .long_press(bus.long_press[c])
    );
  end
  assign bus.any_change = |(bus.rise | bus.fall);
endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: table-driven scoreboard bench for debounce_array (4 ch, 4 stable, 10 long)
module tb_debounce_array;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  debounce_array_if #(.CHANNELS(4)) bus();
  debounce_array #(
    .CHANNELS(4),
    .STABLE_CYCLES(4),
    .RESET_VAL(1'b0),
    .LONG_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] r;
    logic [3:0] f;
    logic       chg;
    logic [3:0] lp;
  } outs_t;
  typedef struct {
    outs_t o;
    int    tag;
  } exp_t;
  typedef struct {
    bit         rst;
    logic [3:0] raw;
    int         n;
    logic [3:0] lvl;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] lp;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  task automatic drive(input bit rst, input logic [3:0] raw, input int n, input logic [3:0] lvl,
                       input logic [3:0] r, input logic [3:0] f, input logic [3:0] lp, input int tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = rst;
      bus.raw_in = raw;
      e.o = {lvl, r, f, |(r | f), LP_EN ? lp : 4'h0};
      e.tag = tag;
      sb.push_back(e);
    end
  endtask
  always @(posedge clk) begin : chk
    exp_t e;
    outs_t a;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {bus.db_level, bus.rise, bus.fall, bus.any_change, bus.long_press};
      total++;
      if (a !== e.o) begin
        bad++;
        $display("FAIL step%0d got lvl=%h r=%h f=%h chg=%b lp=%h want lvl=%h r=%h f=%h chg=%b lp=%h",
                 e.tag, a.lvl, a.r, a.f, a.chg, a.lp, e.o.lvl, e.o.r, e.o.f, e.o.chg, e.o.lp);
      end
    end
  end
  initial begin
    bus.raw_in = 4'h0;
    tbl.push_back(vec_t'{1'b1, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h1, 5, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h1, 3, 4'h1, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 5, 4'h1, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'hA, 5, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'hA, 1, 4'hA, 4'hA, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'hA, 3, 4'hA, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 5, 4'hA, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'hA, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h8, 5, 4'h0, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h8, 1, 4'h8, 4'h8, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h8, 9, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h8, 1, 4'h8, 4'h0, 4'h0, 4'h8});
    tbl.push_back(vec_t'{1'b0, 4'h8, 14, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 5, 4'h8, 4'h0, 4'h0, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h8, 4'h0});
    tbl.push_back(vec_t'{1'b0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0});
    foreach (tbl[i])
      drive(tbl[i].rst, tbl[i].raw, tbl[i].n, tbl[i].lvl, tbl[i].r, tbl[i].f, tbl[i].lp, i);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0, 100 + k);
      drive(1'b0, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 100 + k);
    end
    drive(1'b0, 4'h0, 4, 4'h0, 4'h0, 4'h0, 4'h0, 105);
    drive(1'b0, 4'h4, 4, 4'h0, 4'h0, 4'h0, 4'h0, 200);
    drive(1'b1, 4'h4, 1, 4'h0, 4'h0, 4'h0, 4'h0, 201);
    drive(1'b0, 4'h4, 5, 4'h0, 4'h0, 4'h0, 4'h0, 202);
    drive(1'b0, 4'h4, 1, 4'h4, 4'h4, 4'h0, 4'h0, 203);
    drive(1'b0, 4'h4, 3, 4'h4, 4'h0, 4'h0, 4'h0, 204);
    drive(1'b0, 4'h0, 5, 4'h4, 4'h0, 4'h0, 4'h0, 205);
    drive(1'b0, 4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0, 206);
    drive(1'b0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 207);
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got pending=%0d want pending=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
